// File: rtl/mul_share_arb_pkg.sv
// Shared types and widths for the mul_share_arb multiplier-sharing block.
package mul_share_pkg;
    localparam int OPND_W   = 32;
    localparam int PROD_W   = 64;
    localparam int ID_MAX_W = 3;

    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/mul_share_arb_if.sv
// Bus bundle between requesters, the arbiter, the shared multiplier and the consumer.
interface mul_share_arb_if
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = id_width(NUM_REQ);

    // Every valid/ready pair transfers on a rising edge where both are high;
    // a producer holds valid and its payload stable until that edge.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OPND_W-1:0] req_a;
    logic [NUM_REQ*OPND_W-1:0] req_b;
    logic [OPND_W-1:0]         mul_a;
    logic [OPND_W-1:0]         mul_b;
    logic [PROD_W-1:0]         mul_p;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [PROD_W-1:0]         rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mul_share_fifo.sv
// Synchronous response FIFO; push and pop may coincide even when full.
module mul_share_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop & ~empty;
    // Head is forced to zero when empty so the outputs are clean after reset.
    assign dout   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mul_share_arb.sv
// Round-robin front end sharing one pipelined 32x32 signed multiplier among requesters.
// Defining MUL_SHARE_ARB_STATS_EN adds the stall_cnt output.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_share_arb_if.slave bus
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);
    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_found;
    logic                   credit_ok;
    logic                   accept;
    logic                   land;
    logic                   pop;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       inflight_cnt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ID_W+PROD_W-1:0] fifo_din;
    logic [ID_W+PROD_W-1:0] fifo_dout;
    tag_t                   tags [MUL_LAT+1];
    logic                   unused_tag_bits;

    // Scan downward so the last hit is the first valid index at or after rr_ptr.
    always_comb begin : grant_sel
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // Every in-flight op already owns a FIFO slot; a pop this cycle is not counted.
    assign credit_ok = (int'(fifo_count) + int'(inflight_cnt)) < FIFO_DEPTH;
    assign accept    = grant_found & credit_ok;
    assign land      = tags[MUL_LAT].valid;
    assign pop       = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            bus.mul_a <= '0;
            bus.mul_b <= '0;
        end else if (accept) begin
            rr_ptr    <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            bus.mul_a <= bus.req_a[int'(grant_id)*OPND_W +: OPND_W];
            bus.mul_b <= bus.req_b[int'(grant_id)*OPND_W +: OPND_W];
        end else begin
            bus.mul_a <= '0;
            bus.mul_b <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= MUL_LAT; s++) tags[s] <= '0;
        end else begin
            tags[0].valid <= accept;
            tags[0].id    <= ID_MAX_W'(grant_id);
            for (int s = 1; s <= MUL_LAT; s++) tags[s] <= tags[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_cnt <= '0;
        end else begin
            case ({accept, land})
                2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
                2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    assign fifo_din        = {tags[MUL_LAT].id[ID_W-1:0], bus.mul_p};
    assign unused_tag_bits = ^tags[MUL_LAT].id;

    mul_share_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ID_W + PROD_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (land),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.rsp_valid = ~fifo_empty;
    assign bus.rsp_id    = fifo_dout[PROD_W +: ID_W];
    assign bus.rsp_data  = fifo_dout[PROD_W-1:0];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(land && fifo_full && !pop));

`ifdef MUL_SHARE_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((|bus.req_valid) && !accept && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a two-stage signed multiplier model.
module tb_mul_share_arb;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [ID_W+63:0] exp_q[$];
    logic [63:0]      mul_s1;

    mul_share_arb_if #(.NUM_REQ(NUM_REQ)) bus();
`ifdef MUL_SHARE_ARB_STATS_EN
    logic [31:0] stall_cnt;
`endif

    mul_share_arb #(
        .NUM_REQ    (NUM_REQ),
        .MUL_LAT    (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MUL_SHARE_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: operands seen at edge N produce mul_p at edge N+2
    always @(posedge clk) begin
        mul_s1    <= {{32{bus.mul_a[31]}}, bus.mul_a} * {{32{bus.mul_b[31]}}, bus.mul_b};
        bus.mul_p <= mul_s1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.mul_a !== 32'd0) begin errors++; $display("FAIL reset_mul_a: got %h expected 0", bus.mul_a); end
        checks++; if (bus.mul_b !== 32'd0) begin errors++; $display("FAIL reset_mul_b: got %h expected 0", bus.mul_b); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 64'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
`ifdef MUL_SHARE_ARB_STATS_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_req(2, 32'd7, -32'sd3);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 0) begin
                checks++; if (bus.mul_a !== 32'd7 || bus.mul_b !== 32'hFFFF_FFFD) begin errors++; $display("FAIL single_operands: got %h %h expected 7 fffffffd", bus.mul_a, bus.mul_b); end
            end
            if (n == 1) begin
                checks++; if (bus.mul_a !== 32'd0) begin errors++; $display("FAIL idle_mul_a: got %h expected 0", bus.mul_a); end
            end
            checks++; if (bus.rsp_valid !== (n == 3)) begin errors++; $display("FAIL single_latency n=%0d: got %b expected %b", n, bus.rsp_valid, (n == 3)); end
            if (n == 3) begin
                checks++; if (bus.rsp_id !== 2'd2 || bus.rsp_data !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL single_rsp: got id %0d data %h expected id 2 data ffffffffffffffeb", bus.rsp_id, bus.rsp_data); end
            end
        end
        step();
    endtask

    task automatic test_round_robin();
        int exp_g;
        int accepts;
        logic [ID_W+63:0] exp_e;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i + 1), 32'd100);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        exp_g   = 0;
        accepts = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rr_spurious_rsp: got id %0d data %h expected none", bus.rsp_id, bus.rsp_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_data} !== exp_e) begin errors++; $display("FAIL rr_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_data}, exp_e); end
                end
            end
            if (bus.req_ready != '0) begin
                checks++; if (bus.req_ready !== 4'(1 << exp_g)) begin errors++; $display("FAIL rr_grant: got %b expected %b", bus.req_ready, 4'(1 << exp_g)); end
                exp_q.push_back({2'(exp_g), 64'((exp_g + 1) * 100)});
                exp_g = (exp_g + 1) % NUM_REQ;
                accepts++;
            end
            if (cyc == 3) begin
                checks++; if (accepts != 4) begin errors++; $display("FAIL rr_initial_burst: got %0d accepts expected 4", accepts); end
            end
            step();
            if (accepts >= 8) bus.req_valid = '0;
            if (accepts >= 8 && exp_q.size() == 0) break;
        end
        checks++; if (accepts != 8) begin errors++; $display("FAIL rr_accepts: got %0d expected 8", accepts); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int exp_g;
        int accepts;
        int pops;
        logic [ID_W+63:0] exp_e;
        longint prod;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i + 10), -32'sd5);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111;
        exp_g   = 0;
        accepts = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                checks++; if (bus.req_ready !== 4'(1 << exp_g)) begin errors++; $display("FAIL bp_grant: got %b expected %b", bus.req_ready, 4'(1 << exp_g)); end
                prod = longint'(exp_g + 10) * longint'(-5);
                exp_q.push_back({2'(exp_g), prod});
                exp_g = (exp_g + 1) % NUM_REQ;
                accepts++;
            end
            step();
        end
        @(negedge clk);
        checks++; if (accepts != 4) begin errors++; $display("FAIL bp_accepts: got %0d expected 4", accepts); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_low: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b expected 1", bus.rsp_valid); end
        step();
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        pops = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_spurious_rsp: got id %0d data %h expected none", bus.rsp_id, bus.rsp_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_data} !== exp_e) begin errors++; $display("FAIL bp_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_data}, exp_e); end
                end
                pops++;
            end
            step();
        end
        checks++; if (pops != 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", pops); end
        bus.req_valid = 4'b1111;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume: got %b expected 0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 3) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 64'hFFFF_FFFF_FFFF_FFCE) begin errors++; $display("FAIL bp_resume_rsp: got v%b id %0d data %h expected v1 id 0 data ffffffffffffffce", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
            end
        end
        step();
        exp_q.delete();
    endtask

    task automatic test_extremes();
        int          idx_t [4];
        logic [31:0] a_t   [4];
        logic [31:0] b_t   [4];
        logic [63:0] p_t   [4];
        bit          seen;
        idx_t = '{1, 2, 3, 3};
        a_t   = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        b_t   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        p_t   = '{64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0001,
                  64'h0000_0000_0000_0001, 64'hC000_0000_8000_0000};
        bus.rsp_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            set_req(idx_t[v], a_t[v], b_t[v]);
            bus.req_valid = 4'(1 << idx_t[v]);
            @(negedge clk);
            checks++; if (bus.req_ready !== 4'(1 << idx_t[v])) begin errors++; $display("FAIL ext_grant v%0d: got %b expected %b", v, bus.req_ready, 4'(1 << idx_t[v])); end
            step();
            bus.req_valid = '0;
            seen = 1'b0;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                if (bus.rsp_valid && !seen) begin
                    seen = 1'b1;
                    checks++; if (n != 3) begin errors++; $display("FAIL ext_latency v%0d: got %0d expected 3", v, n); end
                    checks++; if (bus.rsp_id !== 2'(idx_t[v]) || bus.rsp_data !== p_t[v]) begin errors++; $display("FAIL ext_rsp v%0d: got id %0d data %h expected id %0d data %h", v, bus.rsp_id, bus.rsp_data, idx_t[v], p_t[v]); end
                end
            end
            checks++; if (!seen) begin errors++; $display("FAIL ext_timeout v%0d: got no response expected one", v); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        bit got_rsp;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i + 1), 32'd2);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 4'(1 << k)) begin errors++; $display("FAIL mid_grant k%0d: got %b expected %b", k, bus.req_ready, 4'(1 << k)); end
            step();
        end
        rst_n         = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.mul_a !== 32'd0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got mul_a %h rsp_valid %b expected 0 0", bus.mul_a, bus.rsp_valid); end
        step();
        rst_n = 1'b1;
        got_rsp = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) got_rsp = 1'b1;
            step();
        end
        checks++; if (got_rsp) begin errors++; $display("FAIL mid_no_rsp: got rsp_valid 1 expected 0"); end
        set_req(0, 32'd5, 32'd6);
        bus.req_valid = 4'b1001;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 3) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 64'd30) begin errors++; $display("FAIL mid_rsp: got v%b id %0d data %h expected v1 id 0 data 1e", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
            end
        end
        step();
    endtask

`ifdef MUL_SHARE_ARB_STATS_EN
    task automatic test_stats();
        int accepts;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i), 32'd3);
        bus.req_valid = 4'b1111;
        accepts = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) accepts++;
            step();
        end
        @(negedge clk);
        checks++; if (accepts != 4 || stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_fill: got accepts %0d stall_cnt %0d expected 4 0", accepts, stall_cnt); end
        for (int k = 0; k < 10; k++) step();
        @(negedge clk);
        checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL stats_count: got %0d expected 10", stall_cnt); end
        step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        @(negedge clk);
        checks++; if (stall_cnt !== 32'd11) begin errors++; $display("FAIL stats_idle_hold: got %0d expected 11", stall_cnt); end
        step();
    endtask
`endif

    // Sequence and final report
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_reset_mid();
`ifdef MUL_SHARE_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
